// File: rtl/seg7_pkg.sv
// seg7_pkg: active-low 7-segment glyph constants shared by the display drivers
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int DP_BIT = 7;
  localparam logic [15:0][6:0] SEG_TAB = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to active-low segments; 10-15 show letters only in hex mode
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output logic [6:0] seg
);
  assign seg = (nibble > 4'd9 && !hex_mode) ? SEG_BLANK : SEG_TAB[nibble];
endmodule

// File: rtl/display7seg_mux.sv
// display7seg_mux: scans one digit per refresh tick with double-buffered, frame-aligned updates
module display7seg_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 100000,
  parameter bit HEX_MODE   = 1'b0,
  parameter bit LZ_BLANK   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    update_pending,
  output logic                    frame_done,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [7:0]              display7bit
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx, nidx;
  logic [DW-1:0] pend_data, act_data, nxt_data;
  logic [NUM_DIGITS-1:0] pend_dp, act_dp, nxt_dp, blank;
  logic tick, bnd, commit;
  logic [3:0] nib;
  logic [6:0] seg;
  assign tick     = cnt == CW'(CLK_DIV - 1);
  assign bnd      = tick && idx == IW'(NUM_DIGITS - 1);
  assign commit   = bnd && update_pending;
  assign nidx     = idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
  // outputs are built from the buffer as it will be after this edge
  assign nxt_data = commit ? pend_data : act_data;
  assign nxt_dp   = commit ? pend_dp : act_dp;
  assign nib      = nxt_data[4*nidx +: 4];
  always_comb begin
    logic z;
    z = 1'b1;
    blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z = z && nxt_data[4*k +: 4] == 4'd0;
      blank[k] = LZ_BLANK && k > 0 && z;
    end
  end
  seg7_decode u_dec (.nibble(nib), .hex_mode(HEX_MODE), .seg(seg));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt            <= '0;
      idx            <= '0;
      pend_data      <= '0;
      act_data       <= '0;
      pend_dp        <= '0;
      act_dp         <= '0;
      update_pending <= 1'b0;
      frame_done     <= 1'b0;
      anode          <= '1;
      display7bit    <= 8'hFF;
    end else begin
      cnt            <= tick ? '0 : cnt + 1'b1;
      frame_done     <= bnd;
      update_pending <= load | (update_pending & ~bnd);
      if (load) begin
        pend_data <= data_in;
        pend_dp   <= dp_in;
      end
      if (tick) begin
        idx         <= nidx;
        act_data    <= nxt_data;
        act_dp      <= nxt_dp;
        anode       <= ~(NUM_DIGITS'(1) << nidx);
        display7bit <= {~nxt_dp[nidx], blank[nidx] ? SEG_BLANK : seg};
      end
    end
  end
endmodule

// File: tb/tb_display7seg_mux.sv
// tb_display7seg_mux: scoreboard bench over plain, hex and leading-zero-blank variants
module tb_display7seg_mux;
  logic clk = 1'b0, rst = 1'b1, load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0] dp_in = '0;
  logic [3:0] an [3];
  logic [7:0] ds [3];
  logic up [3], fd [3];
  always #5 clk = ~clk;
  display7seg_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b0), .LZ_BLANK(1'b0)) u_plain (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .update_pending(up[0]), .frame_done(fd[0]), .anode(an[0]), .display7bit(ds[0]));
  display7seg_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b1), .LZ_BLANK(1'b0)) u_hex (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .update_pending(up[1]), .frame_done(fd[1]), .anode(an[1]), .display7bit(ds[1]));
  display7seg_mux #(.NUM_DIGITS(4), .CLK_DIV(4), .HEX_MODE(1'b0), .LZ_BLANK(1'b1)) u_lz (
    .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .load(load),
    .update_pending(up[2]), .frame_done(fd[2]), .anode(an[2]), .display7bit(ds[2]));
  typedef struct {
    logic [3:0]      an;
    logic [2:0][7:0] ds;
    logic            fd;
    logic            up;
  } exp_t;
  exp_t sbq[$];
  exp_t cur;
  int n_cmp = 0, n_bad = 0;
  int cyc, idx;
  logic [15:0] pend_d, act_d;
  logic [3:0] pend_p, act_p;
  bit pend;
  logic [7:0] tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask
  function automatic logic [7:0] exp_disp(input int inst);
    logic [3:0] n;
    logic [7:0] g;
    bit blk;
    n = act_d[4*idx +: 4];
    g = tab[n];
    blk = inst == 2 && idx > 0 && (act_d >> (4*idx)) == 16'd0;
    return {~act_p[idx], (blk || (n > 4'd9 && inst != 1)) ? 7'h7F : g[6:0]};
  endfunction
  task automatic model_reset();
    cyc = 0; idx = 0; pend = 0;
    pend_d = '0; act_d = '0; pend_p = '0; act_p = '0;
    cur.an = 4'hF; cur.ds = {3{8'hFF}}; cur.fd = 1'b0; cur.up = 1'b0;
  endtask
  task automatic check_reset();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_display[%0d]", i), ds[i], 8'hFF);
      check($sformatf("rst_anode[%0d]", i), an[i], 4'hF);
      check($sformatf("rst_pending[%0d]", i), up[i], 1'b0);
      check($sformatf("rst_frame_done[%0d]", i), fd[i], 1'b0);
    end
  endtask
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] p);
    exp_t e;
    logic [3:0] oh;
    bit bnd;
    load = ld; data_in = d; dp_in = p;
    cyc++;
    cur.fd = 1'b0;
    if (cyc % 4 == 0) begin
      bnd = idx == 3;
      if (bnd && pend) begin act_d = pend_d; act_p = pend_p; end
      if (bnd) pend = 0;
      idx = (idx + 1) % 4;
      oh = 4'b0001 << idx;
      cur.an = ~oh;
      cur.fd = bnd;
      for (int i = 0; i < 3; i++) cur.ds[i] = exp_disp(i);
    end
    if (ld) begin pend_d = d; pend_p = p; pend = 1; end
    cur.up = pend;
    sbq.push_back(cur);
    @(posedge clk);
    #1;
    load = 1'b0;
    if (sbq.size() == 0) check("scoreboard_empty", 1, 0);
    else begin
      e = sbq.pop_front();
      for (int i = 0; i < 3; i++) begin
        check($sformatf("anode[%0d]", i), an[i], e.an);
        check($sformatf("display[%0d]", i), ds[i], e.ds[i]);
        check($sformatf("frame_done[%0d]", i), fd[i], e.fd);
        check($sformatf("pending[%0d]", i), up[i], e.up);
      end
    end
    @(negedge clk);
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, data_in, dp_in);
  endtask
  task automatic to_boundary();
    for (int i = 0; i < 16 && !(((cyc + 1) % 4 == 0) && idx == 3); i++) step(1'b0, data_in, dp_in);
  endtask
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_reset();
    rst = 1'b0;
    step(1'b1, 16'h1234, 4'h0);
    run(40);
    step(1'b1, 16'h000A, 4'h1);
    run(36);
    step(1'b1, 16'h000A, 4'h0);
    run(36);
    run(6);
    step(1'b1, 16'h0050, 4'h0);
    run(36);
    step(1'b1, 16'h0000, 4'h0);
    run(36);
    step(1'b1, 16'h1111, 4'h0);
    to_boundary();
    step(1'b1, 16'h2222, 4'h0);
    run(40);
    run(5);
    step(1'b1, 16'h9876, 4'hF);
    run(2);
    rst = 1'b1;
    #1;
    check_reset();
    model_reset();
    #2;
    rst = 1'b0;
    run(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
